pc_phase_seq: RTL

PC_PHASE_SEQ -- requirements
Module: pc_phase_seq

---
 rtl/pc_phase_seq.sv | 75 +++++++
 1 files changed

// File: rtl/pc_phase_seq.sv
// pc_phase_seq: dual-rail four-phase program-counter sequencer (NF/DF/NO/DO).
// Optional halt input guarded by macro PC_HALT_EN; it gates only the NF->DF step.
module pc_phase_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       ack,
    input  logic       jmp,
    input  logic [3:0] tgt,
`ifdef PC_HALT_EN
    input  logic       halt,
`endif
    output logic       PH0_t,
    output logic       PH0_f,
    output logic       PC3_t,
    output logic       PC3_f,
    output logic       PC2_t,
    output logic       PC2_f,
    output logic       PC1_t,
    output logic       PC1_f,
    output logic       PC0_t,
    output logic       PC0_f
);
    // bit 0 set marks the DATA states, so the rail decode is a single bit test
    typedef enum logic [1:0] {NF = 2'b00, DF = 2'b01, NO = 2'b10, DO = 2'b11} state_t;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [1:0] ph_q, ph_d;
    logic [3:0] pt_q, pt_d, pf_q, pf_d;
    logic       fetch_ok;

`ifdef PC_HALT_EN
    assign fetch_ok = ~halt;
`else
    assign fetch_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            NF: state_d = (!ack && fetch_ok) ? DF : NF;
            DF: state_d = ack ? NO : DF;
            NO: state_d = !ack ? DO : NO;
            DO: begin
                state_d = ack ? NF : DO;
                pc_d    = ack ? (jmp ? tgt : pc_q + 4'd1) : pc_q;
            end
        endcase
        // rails are decoded from next state so the output flops carry them directly
        ph_d = (state_d == DF) ? 2'b10 : (state_d == DO) ? 2'b01 : 2'b00;
        pt_d = state_d[0] ? pc_d : 4'h0;
        pf_d = state_d[0] ? ~pc_d : 4'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NF;
            pc_q    <= 4'h0;
            ph_q    <= 2'b00;
            pt_q    <= 4'h0;
            pf_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ph_q    <= ph_d;
            pt_q    <= pt_d;
            pf_q    <= pf_d;
        end
    end

    assign {PH0_t, PH0_f}               = ph_q;
    assign {PC3_t, PC2_t, PC1_t, PC0_t} = pt_q;
    assign {PC3_f, PC2_f, PC1_f, PC0_f} = pf_q;
endmodule
